// File: rtl/cpu_hazard_unit_pkg.sv
// cpu_hazard_unit_pkg: shared CPU instruction fields, operand-source encoding and width helper
package cpu_hazard_unit_pkg;
  localparam int INSTR_W     = 32;
  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_W    = 7;
  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int REG_FIELD_W = 5;
  localparam int SRC_REGFILE = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cpu_hazard_match.sv
// cpu_hazard_match: youngest-producer search for one source operand
module cpu_hazard_match
  import cpu_hazard_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RW    = 5,
  parameter int SW    = 2,
  parameter int LAT_W = 2
) (
  input  logic                        is_reg,
  input  logic [RW-1:0]               src_reg,
  input  logic [DEPTH-1:0][RW-1:0]    reg_d,
  input  logic [DEPTH-1:0][LAT_W-1:0] cnt,
  output logic [SW-1:0]               src,
  output logic                        busy
);
  // scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    src  = SW'(SRC_REGFILE);
    busy = 1'b0;
    for (int k = DEPTH; k >= 1; k--)
      if (is_reg && src_reg != '0 && src_reg == reg_d[k-1]) begin
        src  = SW'(k);
        busy = cnt[k-1] != '0;
      end
  end
endmodule

// File: rtl/cpu_hazard_unit.sv
// cpu_hazard_unit: bypass selection and load-use bubble generation for the p2 instruction
module cpu_hazard_unit
  import cpu_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 2,
  parameter int LAT_W    = 2,
  localparam int RW      = clog2(NUM_REGS),
  localparam int SW      = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             p2_valid,
  input  logic [RW-1:0]    p2_reg_a,
  input  logic [RW-1:0]    p2_reg_b,
  input  logic             p2_a_is_reg,
  input  logic             p2_b_is_reg,
  input  logic [RW-1:0]    p2_reg_d,
  input  logic [LAT_W-1:0] p2_latency,
  output logic [SW-1:0]    p2_src_a,
  output logic [SW-1:0]    p2_src_b,
  output logic             p2_bubble,
  output logic [RW-1:0]    wb_reg_d
);
  logic [DEPTH-1:0][RW-1:0]    reg_d_q, reg_d_d;
  logic [DEPTH-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]               src_a, src_b;
  logic                        busy_a, busy_b, take;

  cpu_hazard_match #(.DEPTH(DEPTH), .RW(RW), .SW(SW), .LAT_W(LAT_W)) u_match_a (
    .is_reg(p2_a_is_reg), .src_reg(p2_reg_a), .reg_d(reg_d_q), .cnt(cnt_q),
    .src(src_a), .busy(busy_a)
  );

  cpu_hazard_match #(.DEPTH(DEPTH), .RW(RW), .SW(SW), .LAT_W(LAT_W)) u_match_b (
    .is_reg(p2_b_is_reg), .src_reg(p2_reg_b), .reg_d(reg_d_q), .cnt(cnt_q),
    .src(src_b), .busy(busy_b)
  );

  assign p2_bubble = p2_valid && !flush && !reset && (busy_a || busy_b);
  assign p2_src_a  = (p2_valid && !reset) ? src_a : SW'(SRC_REGFILE);
  assign p2_src_b  = (p2_valid && !reset) ? src_b : SW'(SRC_REGFILE);
  assign take      = p2_valid && !flush && !p2_bubble;
  assign wb_reg_d  = reg_d_q[DEPTH-1];

  // stage 1 takes the p2 entry (or a null op); later stages shift with a saturating countdown
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign reg_d_d[g] = take ? p2_reg_d : '0;
      assign cnt_d[g]   = take ? p2_latency : '0;
    end else begin : g_tail
      assign reg_d_d[g] = reg_d_q[g-1];
      assign cnt_d[g]   = (cnt_q[g-1] == '0) ? '0 : cnt_q[g-1] - LAT_W'(1);
    end
  end

  // advance the in-flight stages unless frozen; reset clears everything even under stall
  always_ff @(posedge clock) begin
    reg_d_q <= reset ? '0 : stall ? reg_d_q : reg_d_d;
    cnt_q   <= reset ? '0 : stall ? cnt_q : cnt_d;
  end

  a_lat_legal: assert property (@(posedge clock) disable iff (reset)
    p2_valid |-> int'(p2_latency) < DEPTH);
endmodule

// File: tb/tb_cpu_hazard_unit.sv
// tb_cpu_hazard_unit: scoreboarded random and scenario stimulus against an age/latency reference model
module tb_cpu_hazard_unit;
  localparam int D = 2;

  typedef struct {
    bit bub;
    bit chk_src;
    int sa;
    int sb;
    int wb;
  } exp_t;

  logic       clock, reset, stall, flush, p2_valid, p2_a_is_reg, p2_b_is_reg;
  logic [4:0] p2_reg_a, p2_reg_b, p2_reg_d, wb_reg_d;
  logic [1:0] p2_latency, p2_src_a, p2_src_b;
  logic       p2_bubble;

  exp_t sb_q[$];
  int   m_dest[D];
  int   m_lat[D];
  bit   last_bub;
  int   n_chk, n_fail;

  cpu_hazard_unit #(.NUM_REGS(32), .DEPTH(D), .LAT_W(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .p2_valid(p2_valid),
    .p2_reg_a(p2_reg_a), .p2_reg_b(p2_reg_b), .p2_a_is_reg(p2_a_is_reg), .p2_b_is_reg(p2_b_is_reg),
    .p2_reg_d(p2_reg_d), .p2_latency(p2_latency), .p2_src_a(p2_src_a), .p2_src_b(p2_src_b),
    .p2_bubble(p2_bubble), .wb_reg_d(wb_reg_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void src_of(input bit isr, input int r, output int s, output bit busy);
    s = 0;
    busy = 0;
    if (!isr || r == 0) return;
    for (int i = 0; i < D; i++)
      if (m_dest[i] == r) begin
        s = i + 1;
        busy = i < m_lat[i];
        return;
      end
  endfunction

  task automatic step(input bit r, input bit s, input bit f, input bit v, input int a, input int b,
                      input bit ai, input bit bi, input int d, input int l);
    exp_t e;
    bit ba, bb, admit;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        m_dest[i] = 0;
        m_lat[i] = 0;
      end
    end else if (!stall) begin
      for (int i = D - 1; i > 0; i--) begin
        m_dest[i] = m_dest[i-1];
        m_lat[i] = m_lat[i-1];
      end
      admit = p2_valid && !flush && !last_bub;
      m_dest[0] = admit ? int'(p2_reg_d) : 0;
      m_lat[0] = admit ? int'(p2_latency) : 0;
    end
    #1;
    reset = r; stall = s; flush = f; p2_valid = v;
    p2_reg_a = 5'(a); p2_reg_b = 5'(b); p2_a_is_reg = ai; p2_b_is_reg = bi;
    p2_reg_d = 5'(d); p2_latency = 2'(l);
    e.wb = m_dest[D-1];
    if (r || !v) begin
      e.bub = 0; e.sa = 0; e.sb = 0; e.chk_src = 1;
    end else begin
      src_of(ai, a, e.sa, ba);
      src_of(bi, b, e.sb, bb);
      e.bub = !f && (ba || bb);
      e.chk_src = !e.bub && !f;
    end
    last_bub = e.bub;
    sb_q.push_back(e);
  endtask

  // compare each pushed expectation against the DUT mid-cycle
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("bubble", int'(p2_bubble), int'(e.bub));
      chk("wb_reg_d", int'(wb_reg_d), e.wb);
      if (e.chk_src) begin
        chk("src_a", int'(p2_src_a), e.sa);
        chk("src_b", int'(p2_src_b), e.sb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall = 0; flush = 0; p2_valid = 0; p2_reg_a = 0; p2_reg_b = 0;
    p2_a_is_reg = 0; p2_b_is_reg = 0; p2_reg_d = 0; p2_latency = 0;
    last_bub = 0; n_chk = 0; n_fail = 0;
    for (int i = 0; i < D; i++) begin
      m_dest[i] = 0;
      m_lat[i] = 0;
    end
    step(1, 0, 0, 1, 3, 4, 1, 1, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // r3 lat 0 then reader
    step(0, 0, 0, 1, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 1, 3, 0, 1, 0, 0, 0);
    // r3 lat 1 then reader in both operands
    step(0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    step(0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
    // youngest writer wins, r0 never bypasses
    step(0, 0, 0, 1, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 1, 5, 5, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    // flush overrides a pending bubble
    step(0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    step(0, 0, 1, 1, 3, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // stall during a bubble
    step(0, 0, 0, 1, 0, 0, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 7, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 7, 7, 1, 1, 0, 0);
    step(0, 0, 0, 1, 7, 7, 1, 1, 0, 0);
    // reset in the middle of a bubble
    step(0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    step(1, 0, 0, 1, 3, 3, 1, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, D - 1)));
    @(negedge clock);
    #1;
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_hazard_unit.md
CPU_HAZARD_UNIT -- requirements
Module: cpu_hazard_unit

Interface
REQ-001 Parameter NUM_REGS, default 32: architectural register count; register 0 is hardwired zero and never hazards.
REQ-002 Parameter DEPTH, default 2: number of in-flight stages tracked (p3..p(2+DEPTH)); legal range 1..8.
REQ-003 Parameter LAT_W, default 2: width of the per-instruction result-latency field.
REQ-004 Derived widths: RW = clog2(NUM_REGS); SW = clog2(DEPTH+1).
REQ-005 clock  in  1  the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  global pipeline freeze.
REQ-008 flush  in  1  taken jump in p3; kills the p2 instruction.
REQ-009 p2_valid  in  1  p2 holds a decoded instruction.
REQ-010 p2_reg_a, p2_reg_b  in  RW each  source register numbers.
REQ-011 p2_a_is_reg, p2_b_is_reg  in  1 each  source is actually read.
REQ-012 p2_reg_d  in  RW  destination register; 0 means no write.
REQ-013 p2_latency  in  LAT_W  extra cycles after p3 before the result can be bypassed; 0 = available from p3.
REQ-014 p2_src_a, p2_src_b  out  SW each  operand source: 0 = register file, k = bypass from stage p(2+k).
REQ-015 p2_bubble  out  1  p2 must be held and a null op injected into p3.
REQ-016 wb_reg_d  out  RW  destination of the instruction leaving the last tracked stage (0 = none).

Function
REQ-017 Each tracked stage k (1..DEPTH) SHALL hold reg_d[k] and cnt[k]; a null op has reg_d = 0.
REQ-018 When stall = 0, stage 1 SHALL load the p2 entry and stage k+1 SHALL load stage k with cnt decremented, saturating at 0.
REQ-019 The p2 entry SHALL be {p2_reg_d, p2_latency} when p2_valid and not flush and not p2_bubble; otherwise it SHALL be a null op.
REQ-020 When stall = 1, all stages SHALL hold their values.
REQ-021 A source matches stage k when is_reg = 1, reg != 0, and reg == reg_d[k].
REQ-022 The youngest matching stage (lowest k) SHALL win.
REQ-023 If the winning stage has cnt == 0, the output SHALL be p2_src = k; with no match, p2_src = 0.
REQ-024 If the winning stage has cnt != 0, p2_bubble SHALL be 1; p2_src is don't-care that cycle.
REQ-025 p2_src and p2_bubble SHALL be combinational from the current p2 inputs and the stage state, with zero latency.
REQ-026 While p2_bubble = 1, a null op SHALL enter stage 1. The bubble repeats each cycle until the producer's cnt reaches 0.
REQ-027 flush SHALL override bubble: p2_bubble = 0 and a null op enters stage 1. Entries already in stages 1..DEPTH are unaffected.
REQ-028 Simultaneous stall and bubble: stall wins. Nothing advances; p2_bubble stays asserted.
REQ-029 p2_valid = 0 SHALL force p2_bubble = 0 and p2_src_a = p2_src_b = 0.
REQ-030 wb_reg_d SHALL equal reg_d[DEPTH].
REQ-031 p2_latency >= DEPTH is illegal and SHALL be flagged by a simulation-only assertion.

Reset
REQ-032 When reset = 1 at a clock edge, every stage SHALL become a null op with cnt = 0, regardless of stall.
REQ-033 While reset = 1, the outputs SHALL be: p2_bubble = 0, p2_src_a = p2_src_b = 0, and wb_reg_d = 0 from the following cycle.
REQ-034 Reset mid-bubble SHALL discard the pending producer; no bubble SHALL follow reset deassertion.

Structure
REQ-035 The operand-source encoding (SRC_REGFILE = 0) and the clog2 helper SHALL live in the shared CPU package with the instruction-field defines.
REQ-036 The per-operand match/priority logic SHALL be one sub-module, cpu_hazard_match, instantiated twice (operands A and B).
REQ-037 The stage array SHALL be a generate loop sized by DEPTH; there SHALL be no per-stage hand-written code.

Verification
REQ-038 Scenario: DEPTH=2; issue r3 lat 0, then a reader of r3 -> p2_src_a = 1, no bubble.
REQ-039 Scenario: issue r3 lat 1, then a reader of r3 in A and B -> one bubble cycle, then p2_src_a = p2_src_b = 2.
REQ-040 Scenario: issue r5 then r5 again, then a reader of r5 -> p2_src = 1 (youngest wins); r0 writers never bypass.
REQ-041 Scenario: bubble pending and flush = 1 in the same cycle -> p2_bubble = 0; null op enters stage 1; wb_reg_d = 0 two cycles later.
REQ-042 Scenario: stall held 3 cycles with lat-1 producer in stage 1 -> stages frozen, bubble held; after release, the sequence completes as in REQ-039.
REQ-043 Scenario: DEPTH=4, LAT_W=2, latency 3, then reset mid-bubble -> after reset: all p2_src = 0, no bubble, wb_reg_d = 0.
